// File: rtl/sys_rst_pkg.sv
`default_nettype none
// ============================================================================
// sys_rst_pkg : state encoding and counter sizing for the reset sequencer
// Revision    : 1.0
// ============================================================================
package sys_rst_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    DEBOUNCE  = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    SW_HOLD   = 3'd4
  } state_t;

  // One spare bit above the largest terminal count keeps every compare overflow-free.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sys_rst_if.sv
`default_nettype none
// ============================================================================
// sys_rst_if : PLL/software-reset inputs and sequenced reset outputs
// Revision   : 1.0
// ============================================================================
interface sys_rst_if #(
  parameter int N_CH = 4
);
  logic            pll_locked_i;
  logic            sw_rst_i;
  logic [N_CH-1:0] rst_n_o;
  logic            ready_o;
  logic            clk_en_o;
  logic [2:0]      state_o;

  modport master (
    input  pll_locked_i, sw_rst_i,
    output rst_n_o, ready_o, clk_en_o, state_o
  );

  modport slave (
    output pll_locked_i, sw_rst_i,
    input  rst_n_o, ready_o, clk_en_o, state_o
  );
endinterface
`default_nettype wire

// File: rtl/sys_rst_seq_sync_bit.sv
`default_nettype none
// ============================================================================
// sync_bit : multi-flop synchroniser for a single asynchronous status bit
// Revision : 1.0
// ============================================================================
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];
endmodule
`default_nettype wire

// File: rtl/sys_rst_seq.sv
`default_nettype none
// ============================================================================
// sys_rst_seq : debounced PLL-lock reset sequencer with staggered channel
//               release, software reset hold and divided clock enable
// Revision    : 1.0
// ============================================================================
module sys_rst_seq
  import sys_rst_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int LOCK_CYCLES   = 4,
  parameter int STAGGER       = 8,
  parameter int SW_RST_CYCLES = 16,
  parameter int DIV           = 4
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  sys_rst_if.master bus
);
  localparam int              CNT_W     = cnt_width(LOCK_CYCLES, STAGGER, SW_RST_CYCLES, DIV);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SW_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [N_CH-1:0]  CH0_ONLY  = N_CH'(1);

  logic             lock_s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [N_CH-1:0]  rst_n, rst_n_nxt;
  logic             ready, ready_nxt;
  logic             start_rel;
  logic             enter_hold;
  logic [CNT_W-1:0] div_cnt;
  logic             clk_en;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .d     (bus.pll_locked_i),
    .q     (lock_s)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
      rst_n <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rst_n <= rst_n_nxt;
      ready <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    rst_n_nxt  = rst_n;
    ready_nxt  = ready;
    start_rel  = 1'b0;
    enter_hold = 1'b0;

    if (!lock_s) begin
      state_nxt = WAIT_LOCK;
      cnt_nxt   = '0;
      rst_n_nxt = '0;
      ready_nxt = 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          state_nxt = DEBOUNCE;
          cnt_nxt   = '0;
        end
        DEBOUNCE: begin
          if (cnt == LOCK_LAST) start_rel = 1'b1;
          else                  cnt_nxt   = cnt + CNT_ONE;
        end
        RELEASE: begin
          if (bus.sw_rst_i) begin
            enter_hold = 1'b1;
          end else if (cnt == STAG_LAST) begin
            // Channels form a thermometer code: shifting in a 1 releases the next index.
            rst_n_nxt = (rst_n << 1) | CH0_ONLY;
            cnt_nxt   = '0;
            if (&rst_n_nxt) begin
              state_nxt = RUN;
              ready_nxt = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        RUN: begin
          if (bus.sw_rst_i) enter_hold = 1'b1;
        end
        SW_HOLD: begin
          if (cnt >= HOLD_LAST) begin
            if (!bus.sw_rst_i) start_rel = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
          rst_n_nxt = '0;
          ready_nxt = 1'b0;
        end
      endcase

      if (enter_hold) begin
        state_nxt = SW_HOLD;
        cnt_nxt   = '0;
        rst_n_nxt = '0;
        ready_nxt = 1'b0;
      end

      if (start_rel) begin
        rst_n_nxt = CH0_ONLY;
        cnt_nxt   = '0;
        state_nxt = (N_CH == 1) ? RUN : RELEASE;
        ready_nxt = (N_CH == 1);
      end
    end
  end

  // Looking at rst_n_nxt as well as rst_n drops the enable on the very edge a reset re-asserts.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_cnt <= '0;
      clk_en  <= 1'b0;
    end else if (!rst_n[0] || !rst_n_nxt[0]) begin
      div_cnt <= '0;
      clk_en  <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      clk_en  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + CNT_ONE;
      clk_en  <= 1'b0;
    end
  end

  assign bus.rst_n_o  = rst_n;
  assign bus.ready_o  = ready;
  assign bus.clk_en_o = clk_en;
  assign bus.state_o  = state;
endmodule
`default_nettype wire

// File: tb/tb_sys_rst_seq.sv
`default_nettype none
// ============================================================================
// tb_sys_rst_seq : default and (N_CH=1, STAGGER=1, DIV=1) sequencers checked
//                  against an edge-time model of lock, release and hold rules
// Revision       : 1.0
// ============================================================================
module tb_sys_rst_seq;
  localparam int SYNC = 2;
  localparam int LC   = 4;
  localparam int SW   = 16;

  int nch_of [2] = '{4, 1};
  int stg_of [2] = '{8, 1};
  int div_of [2] = '{4, 1};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic pll   = 1'b0;
  logic sw    = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int t_e   = 0;

  // Model: edge on which the lock streak began, channel 0 was released, hold was entered.
  int streak [2];
  int rel    [2];
  int hold   [2];
  logic [SYNC-1:0] sh;

  int       rise0 [4];
  int       rise1;
  int       en_first;
  logic [3:0] prev0;
  logic       prev1;

  always #5 clk = ~clk;

  sys_rst_if #(.N_CH(4)) bus0 ();
  sys_rst_if #(.N_CH(1)) bus1 ();

  assign bus0.pll_locked_i = pll;
  assign bus0.sw_rst_i     = sw;
  assign bus1.pll_locked_i = pll;
  assign bus1.sw_rst_i     = sw;

  sys_rst_seq #(
    .N_CH(4), .SYNC_STAGES(SYNC), .LOCK_CYCLES(LC), .STAGGER(8), .SW_RST_CYCLES(SW), .DIV(4)
  ) dut0 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus0)
  );

  sys_rst_seq #(
    .N_CH(1), .SYNC_STAGES(SYNC), .LOCK_CYCLES(LC), .STAGGER(1), .SW_RST_CYCLES(SW), .DIV(1)
  ) dut1 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, t_e);
    end
  endtask

  task automatic model_step(input int i, input logic lk, input logic s);
    if (!lk) begin
      streak[i] = -1;
      rel[i]    = -1;
      hold[i]   = -1;
    end else if (hold[i] >= 0) begin
      if (t_e >= hold[i] + SW && !s) begin
        rel[i]  = t_e;
        hold[i] = -1;
      end
    end else if (rel[i] >= 0) begin
      if (t_e > rel[i] && s) begin
        hold[i] = t_e;
        rel[i]  = -1;
      end
    end else begin
      if (streak[i] < 0) streak[i] = t_e;
      if (t_e == streak[i] + LC) begin
        rel[i]    = t_e;
        streak[i] = -1;
      end
    end
  endtask

  task automatic check_inst(input int i, input logic [3:0] a_rst, input logic a_rdy,
                            input logic a_en, input logic [2:0] a_st);
    logic [3:0] e_rst;
    logic [3:0] mask;
    logic       e_rdy;
    logic       e_en;
    int         e_st;
    e_rst = '0;
    for (int k = 0; k < nch_of[i]; k++)
      if (rel[i] >= 0 && t_e >= rel[i] + k * stg_of[i]) e_rst[k] = 1'b1;
    mask  = 4'((1 << nch_of[i]) - 1);
    e_rdy = (e_rst == mask);
    e_en  = (rel[i] >= 0) && (t_e >= rel[i] + div_of[i]) && ((t_e - rel[i]) % div_of[i] == 0);
    if (hold[i] >= 0)        e_st = 4;
    else if (rel[i] >= 0)    e_st = e_rdy ? 3 : 2;
    else if (streak[i] >= 0) e_st = 1;
    else                     e_st = 0;
    chk($sformatf("i%0d_rst_n", i), int'(a_rst), int'(e_rst));
    chk($sformatf("i%0d_ready", i), int'(a_rdy), int'(e_rdy));
    chk($sformatf("i%0d_clk_en", i), int'(a_en), int'(e_en));
    chk($sformatf("i%0d_state", i), int'(a_st), e_st);
    chk($sformatf("i%0d_order", i), int'(((a_rst + 4'd1) & a_rst) == 4'd0), 1);
  endtask

  initial begin : compare
    logic p_s, s_s, r_s, lk;
    forever begin
      @(posedge clk);
      p_s = pll;
      s_s = sw;
      r_s = rst_n;
      #1;
      if (!r_s) begin
        t_e = 0;
        sh  = '0;
        for (int i = 0; i < 2; i++) begin
          streak[i] = -1;
          rel[i]    = -1;
          hold[i]   = -1;
        end
      end else begin
        t_e++;
        lk = sh[SYNC-1];
        sh = {sh[SYNC-2:0], p_s};
        for (int i = 0; i < 2; i++) model_step(i, lk, s_s);
      end
      check_inst(0, bus0.rst_n_o, bus0.ready_o, bus0.clk_en_o, bus0.state_o);
      check_inst(1, {3'b000, bus1.rst_n_o}, bus1.ready_o, bus1.clk_en_o, bus1.state_o);
      for (int k = 0; k < 4; k++)
        if (bus0.rst_n_o[k] && !prev0[k]) rise0[k] = t_e;
      if (bus0.rst_n_o[0] && !prev0[0]) en_first = -1;
      if (bus0.clk_en_o && en_first < 0) en_first = t_e;
      if (bus1.rst_n_o[0] && !prev1) rise1 = t_e;
      prev0 = bus0.rst_n_o;
      prev1 = bus1.rst_n_o[0];
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int r;
    int w;
    int t0;
    prev0    = '0;
    prev1    = 1'b0;
    rise1    = -1;
    en_first = -1;
    for (int k = 0; k < 4; k++) rise0[k] = -1;
    rst_n = 1'b0;
    pll   = 1'b1;
    sw    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rst_n", int'(bus0.rst_n_o), 0);
    chk("reset_ready", int'(bus0.ready_o), 0);
    chk("reset_state", int'(bus0.state_o), 0);
    chk("reset_clk_en", int'(bus0.clk_en_o), 0);

    // Lock already present when reset lifts: edge 1 is the first edge afterwards.
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("pwr_rise_ch0", rise0[0], 7);
    chk("pwr_rise_ch1", rise0[1], 15);
    chk("pwr_rise_ch2", rise0[2], 23);
    chk("pwr_rise_ch3", rise0[3], 31);
    chk("pwr_first_en", en_first, 11);
    chk("pwr_state_run", int'(bus0.state_o), 3);
    chk("n1_rise", rise1, 7);
    chk("n1_clk_en_on", int'(bus1.clk_en_o), 1);

    // Lock loss in RUN.
    pll = 1'b0;
    t0  = t_e;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus0.rst_n_o == 4'b0000) break;
    end
    chk("loss_latency", t_e - t0, 3);
    chk("loss_ready", int'(bus0.ready_o), 0);
    chk("loss_clk_en", int'(bus0.clk_en_o), 0);
    repeat (4) @(negedge clk);
    pll = 1'b1;
    r   = t_e;
    repeat (40) @(negedge clk);
    chk("relock_ch0", rise0[0] - r, 7);
    chk("relock_ch3", rise0[3] - r, 31);
    chk("relock_first_en", en_first - r, 11);

    // Two-cycle lock glitch landing in the middle of debounce.
    pll = 1'b0;
    repeat (6) @(negedge clk);
    pll = 1'b1;
    r   = t_e;
    repeat (4) @(negedge clk);
    pll = 1'b0;
    repeat (2) @(negedge clk);
    pll = 1'b1;
    repeat (6) @(negedge clk);
    chk("glitch_held_at_r12", int'(bus0.rst_n_o), 0);
    repeat (30) @(negedge clk);
    chk("glitch_release", rise0[0] - r, 13);

    // Single-cycle software reset request in RUN.
    sw = 1'b1;
    w  = t_e + 1;
    @(negedge clk);
    sw = 1'b0;
    chk("swp_all_low", int'(bus0.rst_n_o), 0);
    chk("swp_state_hold", int'(bus0.state_o), 4);
    repeat (45) @(negedge clk);
    chk("swp_rise_ch0", rise0[0] - w, 16);
    chk("swp_rise_ch1", rise0[1] - w, 24);
    chk("swp_n1_rise", rise1 - w, 16);

    // Software reset held 40 cycles: release on the first edge it is seen low.
    sw = 1'b1;
    w  = t_e + 1;
    repeat (40) @(negedge clk);
    chk("swh_still_hold", int'(bus0.state_o), 4);
    sw = 1'b0;
    repeat (40) @(negedge clk);
    chk("swh_rise_ch0", rise0[0] - w, 40);
    chk("swh_rise_ch3", rise0[3] - w, 64);
    chk("swh_ready", int'(bus0.ready_o), 1);
    chk("swh_n1_rise", rise1 - w, 40);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sys_rst_seq.md
Name: sys_rst_seq

Overview:
Parametrised successor to the system clock/reset controller.
- Synchronises the PLL lock and debounces it.
- Releases N_CH reset domains one after another in a staggered order.
- Supports software-requested resets and re-sequences on loss of lock.
- Generates a divided clock-enable strobe. This replaces the fixed clock divider with a single-clock enable scheme.
- Sits between the PLL and all subsystem reset inputs.

Parameters:
N_CH, 4, number of reset channels (>=1); channel 0 releases first.
SYNC_STAGES, 2, flops in the lock synchroniser (>=2).
LOCK_CYCLES, 4, consecutive synchronised-lock cycles required before release (>=1).
STAGGER, 8, cycles between release of channel k and channel k+1 (>=1).
SW_RST_CYCLES, 16, minimum software-reset hold cycles (>=1).
DIV, 4, clock-enable division ratio (>=1).

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
pll_locked_i  in  1  PLL lock, asynchronous to clk_i
sw_rst_i  in  1  synchronous software reset request, level
rst_n_o  out  N_CH  per-channel active-low resets, registered
ready_o  out  1  all channels released
clk_en_o  out  1  one-cycle enable every DIV cycles
state_o  out  3  current FSM state (debug)

Behaviour:
Reset and clocking
- Single clock domain. rst_n_i is asynchronous, active-low, and clears every flop.
- Reset values: rst_n_o=0, ready_o=0, clk_en_o=0, state=WAIT_LOCK, all counters=0.

Lock synchroniser
- lock_s is the last stage of an SYNC_STAGES-flop synchroniser on pll_locked_i.

FSM states: WAIT_LOCK, DEBOUNCE, RELEASE, RUN, SW_HOLD.
- WAIT_LOCK: when lock_s=1, go to DEBOUNCE with cnt=0.
- DEBOUNCE: cnt increments each cycle while lock_s=1. When cnt==LOCK_CYCLES-1:
  - go to RELEASE;
  - rst_n_o[0] rises on that same edge;
  - idx=0, cnt=0.
- RELEASE: every STAGGER cycles, the next channel's bit rises. When bit N_CH-1 rises, enter RUN and raise ready_o on the same edge.
- If N_CH=1, DEBOUNCE goes directly to RUN (rst_n_o[0] and ready_o rise together).
- RUN: hold all resets released.
- SW_HOLD: on entry, all rst_n_o=0, ready_o=0, cnt=0. Exit to RELEASE (rst_n_o[0] rises on the exit edge) when cnt>=SW_RST_CYCLES-1 and sw_rst_i=0. cnt saturates.

Lock loss (priority 1)
- lock_s=0 sampled in any state other than WAIT_LOCK forces WAIT_LOCK on that edge.
- All rst_n_o=0, ready_o=0, counters cleared.
- Latency from pll_locked_i falling to rst_n_o=0: SYNC_STAGES+1 edges.
- A lock glitch during DEBOUNCE restarts the debounce.

Software reset (priority 2)
- sw_rst_i=1 sampled in RELEASE or RUN enters SW_HOLD.
- Ignored in WAIT_LOCK and DEBOUNCE.

Reset ordering invariant
- Channels only ever assert together and release in ascending index order.
- rst_n_o[k]=1 implies rst_n_o[j]=1 for all j<k.

Divider
- div_cnt is held at 0 while rst_n_o[0]=0. Otherwise it increments and wraps at DIV-1.
- clk_en_o is registered and is high for the one cycle after the edge on which div_cnt wraps.
- Result: the first pulse is high after edge E+DIV, where E is the edge on which rst_n_o[0] rises. The period is DIV cycles.
- DIV=1 gives clk_en_o=1 continuously from E+1.
- Any reset re-assertion clears clk_en_o on the same edge.

Counter width
- $clog2 of the maximum of LOCK_CYCLES, STAGGER, SW_RST_CYCLES and DIV, plus 1. No overflow is possible.

Decomposition:
- Package sys_rst_pkg:
  - state enum (3-bit, encodings WAIT_LOCK=0, DEBOUNCE=1, RELEASE=2, RUN=3, SW_HOLD=4) driving state_o;
  - CNT_W computation function.
- Sub-module: sync_bit, a parametrised SYNC_STAGES-flop synchroniser with async active-low reset to 0. It is reused elsewhere for other asynchronous status bits.

Test Plan:
- Defaults, pll_locked_i=1 before rst_n_i rises (edge 1 = first edge after reset release) -> rst_n_o[0] rises at edge 7, [1] at 15, [2] at 23, [3] at 31; ready_o=1 at edge 31; state_o=3.
- Defaults, after ready -> clk_en_o high one cycle at edge 11 then every 4 cycles; no pulse before edge 11.
- In RUN, drop pll_locked_i -> rst_n_o=4'b0000 and ready_o=0 exactly 3 edges later, clk_en_o=0. Restore lock -> full sequence repeats with identical spacing.
- Lock glitch of 2 cycles during DEBOUNCE -> no channel released; debounce restarts and release occurs LOCK_CYCLES cycles after lock_s is stable.
- sw_rst_i pulse of 1 cycle in RUN -> all resets 0 for 16 cycles, then staggered release. sw_rst_i held 40 cycles -> release begins on the first edge after sw_rst_i falls.
- Parameter sweep N_CH=1, DIV=1, STAGGER=1 -> rst_n_o and ready_o rise on the same edge; clk_en_o constant 1 from the next edge; ordering invariant asserted throughout all tests.
